// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares a single-event-per-cycle parking occupancy core between NUM_GATES
// physical gates. Requests are picked round-robin, one at a time. Exits are
// always issued. An entry is issued only if the matching space flag
// (university or public) was set when the request was picked. Otherwise the
// gate is denied. After each grant or deny the arbiter waits SETTLE_CYCLES
// cycles so the core's counters and flags can update.
//
// Timing: the winner is latched at edge k (IDLE -> RESPOND). The registered
// grant/deny and command pulses appear after edge k+1. busy stays high for
// that cycle and for the SETTLE_CYCLES cycles after it.
//
// Optional feature macro: PARKING_EXIT_PRIORITY_EN
//   defined   - when any requesting gate is an exit, round-robin runs over
//               exits only. Entries are served only when no exit is pending.
//   undefined - plain round-robin over all requests.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   gate_req[NUM_GATES]        per-gate request level, held until grant/deny
//   gate_is_exit[NUM_GATES]    1 = exit request, 0 = entry
//   gate_is_uni[NUM_GATES]     1 = university car, 0 = public
//   uni_is_vacated_space       core flag: university space available
//   is_vacated_space           core flag: public space available
//   gate_grant[NUM_GATES]      one-hot pulse: request accepted and issued
//   gate_deny[NUM_GATES]       one-hot pulse: entry refused, section full
//   car_entered, is_uni_car_entered   entry command pulse + qualifier
//   car_exited,  is_uni_car_exited    exit command pulse + qualifier
//   busy                       high while a decision is presented or settling
//   grant_count[CNT_W]         saturating count of issued commands
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
  parameter int NUM_GATES     = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_is_exit,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic [NUM_GATES-1:0] gate_grant,
  output logic [NUM_GATES-1:0] gate_deny,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic                 busy,
  output logic [CNT_W-1:0]     grant_count
);

  localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_GATE   = IDX_W'(NUM_GATES - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESPOND = 2'd1,
    S_SETTLE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 win_exit_q, win_exit_d;
  logic                 win_uni_q, win_uni_d;
  logic                 win_space_q, win_space_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]     count_d;
  logic [NUM_GATES-1:0] grant_d, deny_d;
  logic                 car_entered_d, uni_entered_d;
  logic                 car_exited_d, uni_exited_d;
  logic                 busy_d;

  // ---------------------------------------------------------------------------
  // Candidate requests. Masking with gate_req keeps the direction bits of idle
  // gates out of the decision.
  // ---------------------------------------------------------------------------
  logic [NUM_GATES-1:0] req_eff;
`ifdef PARKING_EXIT_PRIORITY_EN
  logic [NUM_GATES-1:0] exit_req;
  assign exit_req = gate_req & gate_is_exit;
  assign req_eff  = (|exit_req) ? exit_req : gate_req;
`else
  assign req_eff  = gate_req;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin winner: the first candidate at or above rr_ptr, with wrap.
  // ---------------------------------------------------------------------------
  logic             found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin : win_search
    int scan;
    // NOTE: every variable written in a combinational block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    found   = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int i = 0; i < NUM_GATES; i++) begin
      scan = int'(rr_ptr_q) + i;
      if (scan >= NUM_GATES) scan = scan - NUM_GATES;
      if (!found && req_eff[IDX_W'(scan)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(scan);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed here and registered
  // below, so every port comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    win_exit_d    = win_exit_q;
    win_uni_d     = win_uni_q;
    win_space_d   = win_space_q;
    settle_d      = settle_q;
    count_d       = grant_count;
    grant_d       = '0;
    deny_d        = '0;
    car_entered_d = 1'b0;
    uni_entered_d = 1'b0;
    car_exited_d  = 1'b0;
    uni_exited_d  = 1'b0;
    busy_d        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d      = win_idx;
          win_exit_d = gate_is_exit[win_idx];
          win_uni_d  = gate_is_uni[win_idx];
          // The space flag is frozen here, so the decision made in RESPOND
          // uses the core state from the cycle the request was picked.
          win_space_d = gate_is_uni[win_idx] ? uni_is_vacated_space
                                             : is_vacated_space;
          state_d    = S_RESPOND;
        end
      end

      S_RESPOND: begin
        if (win_exit_q) begin
          // Exits are always issued. The core ignores an exit at count 0.
          car_exited_d    = 1'b1;
          uni_exited_d    = win_uni_q;
          grant_d[win_q]  = 1'b1;
        end else if (win_space_q) begin
          car_entered_d   = 1'b1;
          uni_entered_d   = win_uni_q;
          grant_d[win_q]  = 1'b1;
        end else begin
          deny_d[win_q]   = 1'b1;
        end

        if ((win_exit_q || win_space_q) && (grant_count != '1))
          count_d = grant_count + CNT_W'(1);

        rr_ptr_d = (win_q == LAST_GATE) ? '0 : win_q + IDX_W'(1);
        settle_d = '0;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d  = S_IDLE;
        else                         settle_d = settle_q + SET_W'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the asynchronous reset clears the pulse registers as well as the
      // FSM, so an in-flight grant or command disappears at once.
      state_q            <= S_IDLE;
      rr_ptr_q           <= '0;
      win_q              <= '0;
      win_exit_q         <= 1'b0;
      win_uni_q          <= 1'b0;
      win_space_q        <= 1'b0;
      settle_q           <= '0;
      grant_count        <= '0;
      gate_grant         <= '0;
      gate_deny          <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      rr_ptr_q           <= rr_ptr_d;
      win_q              <= win_d;
      win_exit_q         <= win_exit_d;
      win_uni_q          <= win_uni_d;
      win_space_q        <= win_space_d;
      settle_q           <= settle_d;
      grant_count        <= count_d;
      gate_grant         <= grant_d;
      gate_deny          <= deny_d;
      car_entered        <= car_entered_d;
      is_uni_car_entered <= uni_entered_d;
      car_exited         <= car_exited_d;
      is_uni_car_exited  <= uni_exited_d;
      busy               <= busy_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Scoreboard bench. Each expected decision is pushed when the matching request
// is driven and popped when a grant/deny appears. The bench plays the
// requester and drops a gate's request as soon as that gate is answered.
// A second instance with a 3-bit counter shares the stimulus so that counter
// saturation is reached within a short run.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] gate_req, gate_is_exit, gate_is_uni;
  logic         uni_vac, vac;

  logic [N-1:0] gate_grant, gate_deny;
  logic         car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic         busy;
  logic [15:0]  grant_count;

  logic [N-1:0] grant_s, deny_s;
  logic         ce_s, ue_s, cx_s, ux_s, busy_s;
  logic [2:0]   grant_count_s;

  always #5 clk = ~clk;

  parking_gate_arbiter #(.NUM_GATES(N), .SETTLE_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .gate_req(gate_req), .gate_is_exit(gate_is_exit), .gate_is_uni(gate_is_uni),
    .uni_is_vacated_space(uni_vac), .is_vacated_space(vac),
    .gate_grant(gate_grant), .gate_deny(gate_deny),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .busy(busy), .grant_count(grant_count)
  );

  parking_gate_arbiter #(.NUM_GATES(N), .SETTLE_CYCLES(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .gate_req(gate_req), .gate_is_exit(gate_is_exit), .gate_is_uni(gate_is_uni),
    .uni_is_vacated_space(uni_vac), .is_vacated_space(vac),
    .gate_grant(grant_s), .gate_deny(deny_s),
    .car_entered(ce_s), .is_uni_car_entered(ue_s),
    .car_exited(cx_s), .is_uni_car_exited(ux_s),
    .busy(busy_s), .grant_count(grant_count_s)
  );

  typedef struct {
    int         gate;
    bit         deny;
    bit         ex;
    bit         uni;
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  exp_t        sb[$];
  int          ev_cyc[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          seen;
  logic [15:0] m_cnt;
  logic [2:0]  m_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Raise a request on gate g.
  task automatic drive_req(input int g, input bit ex, input bit uni);
    gate_req[g]     = 1'b1;
    gate_is_exit[g] = ex;
    gate_is_uni[g]  = uni;
  endtask

  // Predict the decision for gate g from the current flags and push it.
  task automatic sb_push(input int g, input bit ex, input bit uni);
    exp_t e;
    e.gate = g;
    e.ex   = ex;
    e.uni  = uni;
    e.deny = !ex && !(uni ? uni_vac : vac);
    if (!e.deny) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_sat != 3'h7)     m_sat = m_sat + 3'd1;
    end
    e.cnt = m_cnt;
    e.sat = m_sat;
    sb.push_back(e);
  endtask

  // One cycle: sample on the falling edge, score any decision, answer requester.
  task automatic step();
    exp_t       e;
    logic [3:0] mask, exp_cmd, got_cmd;
    @(negedge clk);
    cyc++;
    seen    = 1'b0;
    got_cmd = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
    if (|(gate_grant | gate_deny)) begin
      seen = 1'b1;
      ev_cyc.push_back(cyc);
      check("one_decision", $countones(gate_grant | gate_deny), 1);
      if (sb.size() == 0) begin
        check("unexpected_event", {28'd0, gate_grant | gate_deny}, 0);
      end else begin
        e       = sb.pop_front();
        mask    = 4'(1 << e.gate);
        exp_cmd = {!e.deny && !e.ex, !e.deny && !e.ex && e.uni, e.ex, e.ex && e.uni};
        check($sformatf("grant_g%0d", e.gate), gate_grant, e.deny ? 4'h0 : mask);
        check($sformatf("deny_g%0d", e.gate),  gate_deny,  e.deny ? mask : 4'h0);
        check($sformatf("cmd_g%0d", e.gate),   got_cmd, exp_cmd);
        check("grant_count", grant_count, e.cnt);
        check("grant_count_sat", grant_count_s, e.sat);
      end
      gate_req = gate_req & ~(gate_grant | gate_deny);
    end else if (got_cmd != 4'h0) begin
      check("stray_cmd", got_cmd, 0);
    end
  endtask

  // Run until every expected decision has been seen and the arbiter is idle.
  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (sb.size() == 0) && (gate_req == '0) && !busy;
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    gate_req     = '0;
    gate_is_exit = '0;
    gate_is_uni  = '0;
    uni_vac      = 1'b1;
    vac          = 1'b1;
    m_cnt        = '0;
    m_sat        = '0;

    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_grant", gate_grant, 0);
    check("rst_count", grant_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a decision is on the outputs: public exit on gate 1.
    drive_req(1, 1'b1, 1'b0);
    sb_push(1, 1'b1, 1'b0);
    for (int i = 0; i < 10 && !seen; i++) step();
    check("pre_reset_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_grant", gate_grant, 0);
    check("abort_exit", car_exited, 0);
    check("abort_busy", busy, 0);
    check("abort_count", grant_count, 0);
    m_cnt    = '0;
    m_sat    = '0;
    gate_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_busy", busy, 0);
    end

    // Single public entry on gate 2: one-cycle pulse, then two busy cycles.
    drive_req(2, 1'b0, 1'b0);
    sb_push(2, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) step();
    check("g2_seen", seen, 1);
    check("g2_busy0", busy, 1);
    step();
    check("g2_pulse_len", {gate_grant, car_entered}, 0);
    check("g2_busy1", busy, 1);
    step();
    check("g2_busy2", busy, 1);
    step();
    check("g2_busy3", busy, 0);

    // University entry on gate 0 with no university space: denied.
    uni_vac = 1'b0;
    drive_req(0, 1'b0, 1'b1);
    sb_push(0, 1'b0, 1'b1);
    drain(20);
    uni_vac = 1'b1;

    // rr_ptr should now be 1: gates 0 and 1 together -> 1 first, then 0.
    drive_req(0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 1'b0);
    sb_push(1, 1'b0, 1'b0);
    sb_push(0, 1'b0, 1'b0);
    drain(30);

    // Gate 3 alone moves rr_ptr back to 0.
    drive_req(3, 1'b0, 1'b1);
    sb_push(3, 1'b0, 1'b1);
    drain(20);

    // Gates 0, 1, 3 together: served 0, 1, 3, four cycles apart.
    ev_cyc.delete();
    drive_req(0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 1'b1);
    drive_req(3, 1'b0, 1'b0);
    sb_push(0, 1'b0, 1'b0);
    sb_push(1, 1'b0, 1'b1);
    sb_push(3, 1'b0, 1'b0);
    drain(40);
    check("rr_events", ev_cyc.size(), 3);
    if (ev_cyc.size() == 3) begin
      check("rr_gap01", ev_cyc[1] - ev_cyc[0], 4);
      check("rr_gap13", ev_cyc[2] - ev_cyc[1], 4);
    end

    // Gate 0 public entry and gate 2 university exit together, rr_ptr = 0.
    drive_req(0, 1'b0, 1'b0);
    drive_req(2, 1'b1, 1'b1);
`ifdef PARKING_EXIT_PRIORITY_EN
    sb_push(2, 1'b1, 1'b1);
    sb_push(0, 1'b0, 1'b0);
`else
    sb_push(0, 1'b0, 1'b0);
    sb_push(2, 1'b1, 1'b1);
`endif
    drain(30);

    // Random single requests with random space flags; the small counter
    // instance is already saturated and must stay at 7.
    for (int k = 0; k < 8; k++) begin
      int g;
      bit ex, uni;
      g       = int'($urandom_range(0, N - 1));
      ex      = 1'($urandom_range(0, 1));
      uni     = 1'($urandom_range(0, 1));
      vac     = 1'($urandom_range(0, 1));
      uni_vac = 1'($urandom_range(0, 1));
      drive_req(g, ex, uni);
      sb_push(g, ex, uni);
      drain(20);
    end
    check("sat_final", grant_count_s, 3'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Shares the single-event-per-cycle parking occupancy core between NUM_GATES physical gates; each gate raises an entry or exit request.
- Round-robin picks one request at a time and checks the core's space flags for entries.
- Accepted requests become a one-cycle command pulse on the core's car_entered/is_uni_car_entered/car_exited/is_uni_car_exited inputs; entries with no space are denied.
- A settle window lets the core's counters and flags update before the next decision.

Parameters:
- NUM_GATES, 4, number of requesting gates (2..8).
- SETTLE_CYCLES, 2, cycles the arbiter idles after each grant/deny (>=1).
- CNT_W, 16, width of the issued-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- gate_req  in  NUM_GATES  per-gate request level, held until grant/deny.
- gate_is_exit  in  NUM_GATES  1 = exit request, 0 = entry; stable while req high.
- gate_is_uni  in  NUM_GATES  1 = university car, 0 = public; stable while req high.
- uni_is_vacated_space  in  1  core flag: university space available.
- is_vacated_space  in  1  core flag: public space available.
- gate_grant  out  NUM_GATES  one-hot pulse: request accepted and issued.
- gate_deny  out  NUM_GATES  one-hot pulse: entry refused, lot section full.
- car_entered  out  1  command pulse to core.
- is_uni_car_entered  out  1  qualifier, valid with car_entered.
- car_exited  out  1  command pulse to core.
- is_uni_car_exited  out  1  qualifier, valid with car_exited.
- busy  out  1  high in RESPOND and SETTLE.
- grant_count  out  CNT_W  number of issued commands, saturating.

Behaviour:
- Reset (async, rst_n low): state IDLE, rr_ptr = 0, settle counter = 0, grant_count = 0. All pulse outputs and busy are 0. Reset mid-RESPOND/SETTLE aborts the pulse immediately.
- FSM states: IDLE, RESPOND, SETTLE. All outputs are registered.
- IDLE, no gate_req bit set: stay in IDLE.
- IDLE, any gate_req bit set:
  - Winner w = first set bit searching upward from rr_ptr, with wrap-around.
  - Latch w, gate_is_exit[w] and gate_is_uni[w]; go to RESPOND.
- RESPOND lasts exactly one cycle; busy = 1.
  - Exit request: car_exited = 1, is_uni_car_exited = gate_is_uni[w], gate_grant[w] = 1.
  - Entry request with uni = 1: accepted if uni_is_vacated_space = 1 (flag sampled on the IDLE->RESPOND edge). Then car_entered = 1, is_uni_car_entered = 1, gate_grant[w] = 1.
  - Entry request with uni = 0: accepted if is_vacated_space = 1 (sampled on the same edge). Then car_entered = 1, is_uni_car_entered = 0, gate_grant[w] = 1.
  - Entry with the relevant flag 0: gate_deny[w] = 1; no command pulse.
  - Exits are always issued; the core ignores an exit when its count is 0.
  - rr_ptr <= (w+1) mod NUM_GATES on both grant and deny.
  - grant_count += 1 on a grant only; holds at all-ones.
- SETTLE: busy = 1 for SETTLE_CYCLES cycles, then IDLE. Requests are not sampled during SETTLE.
- Latency: request seen in IDLE at edge k -> grant/deny and command visible after edge k+1 -> next arbitration at edge k+1+SETTLE_CYCLES+1 at the earliest.
- Requester contract: deassert gate_req within SETTLE_CYCLES cycles after seeing grant/deny. A req still high on return to IDLE is a new request.
- At most one bit of gate_grant | gate_deny is set, and at most one command pulse, per cycle.
- Simultaneous requests: only the winner is served; the rest wait with no loss.
- Out-of-range or X inputs on non-requesting gates are ignored.

Optional Feature:
- Macro: PARKING_EXIT_PRIORITY_EN.
- Defined: in IDLE, if any requesting gate has gate_is_exit = 1, the winner is chosen by round-robin among exits only; entries are served only when no exit is pending. Exits free space before entries are judged.
- Undefined: plain round-robin over all requests regardless of direction.

Test Plan:
- Reset: rst_n low mid-RESPOND -> all outputs 0 immediately, grant_count = 0; after release an idle bus keeps busy = 0.
- Single public entry on gate 2, is_vacated_space = 1 -> gate_grant = 4'b0100, car_entered = 1, is_uni_car_entered = 0 for exactly 1 cycle, then busy for 2 cycles, grant_count = 1.
- University entry on gate 0 with uni_is_vacated_space = 0 -> gate_deny = 4'b0001, no car_entered pulse, grant_count unchanged, rr_ptr = 1.
- Gates 0, 1 and 3 all request together (entries, space available) -> grants in order 0, 1, 3, spaced 4 cycles apart (1 RESPOND + 2 SETTLE + 1 IDLE); the next round starts at gate 0.
- With PARKING_EXIT_PRIORITY_EN: gate 0 public entry and gate 2 university exit request together, rr_ptr = 0 -> gate 2 served first (car_exited = 1, is_uni_car_exited = 1), then gate 0. Without the macro -> gate 0 first.
- Saturation: preload or run until grant_count = 16'hFFFF -> a further grant leaves it at 16'hFFFF.
